// File: rtl/code_mem_arbiter_if.sv
// Code memory arbiter bus: fetch side, loader port and memory lines.
// slave = arbiter, master = surrounding fetch/loader/memory environment.
interface code_mem_arbiter_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic [WORD_SIZE-1:0] fetch_data;
  logic                 fetch_stall;
  logic                 loader_req;
  logic                 loader_we;
  logic [ADDR_SIZE-1:0] loader_addr;
  logic [WORD_SIZE-1:0] loader_wdata;
  logic                 loader_lock;
  logic                 loader_ack;
  logic [WORD_SIZE-1:0] loader_rdata;
  logic                 cpu_reset;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  fetch_addr, loader_req, loader_we,
    input  loader_addr, loader_wdata, loader_lock,
    input  mem_rdata,
    output fetch_data, fetch_stall, loader_ack,
    output loader_rdata, cpu_reset,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_addr, loader_req, loader_we,
    output loader_addr, loader_wdata, loader_lock,
    output mem_rdata,
    input  fetch_data, fetch_stall, loader_ack,
    input  loader_rdata, cpu_reset,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/code_mem_arbiter.sv
// Single-port code memory arbiter between instruction fetch and the
// program loader/debug port, with locked bulk-download mode.
module code_mem_arbiter #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input logic clock,
  input logic reset,
  code_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rd_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      ack_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      cpu_reset_q <= cpu_reset_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (bus.loader_req) state_d = LOAD;
      LOAD:  state_d = DONE;
      DONE: begin
        if (bus.loader_req && bus.loader_lock)
          state_d = LOAD;
        else
          state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory returns the loader word during DONE; hold it once DONE ends.
  assign rd_done = (state_q == DONE) && !bus.loader_we;

  always_comb begin
    ack_d       = (state_d == DONE);
    cpu_reset_d = cpu_reset_q;
    if (bus.loader_lock)
      cpu_reset_d = 1'b1;
    else if (state_d == FETCH)
      cpu_reset_d = 1'b0;
    rdata_d = rd_done ? bus.mem_rdata : rdata_q;
  end

  always_comb begin
    bus.mem_addr    = bus.fetch_addr;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = bus.loader_wdata;
    bus.fetch_stall = 1'b0;
    unique case (state_q)
      FETCH: ;
      LOAD: begin
        bus.mem_addr    = bus.loader_addr;
        bus.mem_we      = bus.loader_we;
        bus.fetch_stall = 1'b1;
      end
      DONE: bus.fetch_stall = 1'b1;
      default: ;
    endcase
  end

  assign bus.fetch_data   = bus.mem_rdata;
  assign bus.loader_ack   = ack_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.loader_rdata = rd_done ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Scoreboard bench for code_mem_arbiter with a 1-cycle sync memory model.
module tb_code_mem_arbiter;

  logic clk;
  logic rst_n;

  code_mem_arbiter_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus_if ();

  code_mem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] mem     [0:255];
  logic [17:0] ref_mem [0:255];

  always @(posedge clk) begin
    bus_if.mem_rdata <= mem[bus_if.mem_addr[7:0]];
    if (bus_if.mem_we)
      mem[bus_if.mem_addr[7:0]] = bus_if.mem_wdata;
  end

  typedef struct {
    logic        rd;
    logic [17:0] data;
  } sb_t;

  sb_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [17:0] a,
                      input logic [17:0] d);
    sb_t e;
    e.rd = !we;
    if (we) begin
      ref_mem[a[7:0]] = d;
      e.data = d;
    end else begin
      e.data = ref_mem[a[7:0]];
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.loader_ack) begin
      sb_t e;
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.rd) chk("sb_rdata", bus_if.loader_rdata, e.data);
      end
    end
  end

  task automatic access(input logic we, input logic [17:0] a,
                        input logic [17:0] d);
    logic [17:0] exp;
    @(posedge clk); #1;
    bus_if.loader_req   = 1'b1;
    bus_if.loader_we    = we;
    bus_if.loader_addr  = a;
    bus_if.loader_wdata = d;
    push(we, a, d);
    exp = ref_mem[a[7:0]];
    @(negedge clk);
    chk("req_stall0", bus_if.fetch_stall, 0);
    chk("req_ack0", bus_if.loader_ack, 0);
    @(negedge clk);
    chk("load_addr", bus_if.mem_addr, a);
    chk("load_we", bus_if.mem_we, we);
    chk("load_stall", bus_if.fetch_stall, 1);
    if (we) chk("load_wdata", bus_if.mem_wdata, d);
    @(negedge clk);
    chk("done_ack", bus_if.loader_ack, 1);
    chk("done_stall", bus_if.fetch_stall, 1);
    chk("done_addr", bus_if.mem_addr, bus_if.fetch_addr);
    chk("done_we", bus_if.mem_we, 0);
    if (we) chk("wr_mem", mem[a[7:0]], d);
    bus_if.loader_req = 1'b0;
    @(negedge clk);
    chk("post_stall", bus_if.fetch_stall, 0);
    chk("post_ack", bus_if.loader_ack, 0);
    if (!we) chk("rdata_hold", bus_if.loader_rdata, exp);
  endtask

  int acks;
  int gap;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[5] = 18'h12345;
    ref_mem[5] = 18'h12345;
    rst_n = 1'b0;
    bus_if.fetch_addr   = '0;
    bus_if.loader_req   = 1'b0;
    bus_if.loader_we    = 1'b0;
    bus_if.loader_addr  = '0;
    bus_if.loader_wdata = '0;
    bus_if.loader_lock  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus_if.loader_ack, 0);
    chk("rst_rdata", bus_if.loader_rdata, 0);
    chk("rst_cpu_reset", bus_if.cpu_reset, 0);
    chk("rst_stall", bus_if.fetch_stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_if.fetch_addr = 18'(i);
      @(negedge clk);
      chk("idle_addr", bus_if.mem_addr, i);
      chk("idle_we", bus_if.mem_we, 0);
      chk("idle_stall", bus_if.fetch_stall, 0);
      chk("idle_ack", bus_if.loader_ack, 0);
    end

    bus_if.fetch_addr = 18'h00003;
    access(1'b1, 18'h00010, 18'h2ABCD);
    access(1'b0, 18'h00005, 18'h0);
    access(1'b0, 18'h00010, 18'h0);

    @(posedge clk); #1;
    bus_if.loader_req   = 1'b1;
    bus_if.loader_we    = 1'b1;
    bus_if.loader_addr  = 18'h00020;
    bus_if.loader_wdata = 18'h00100;
    push(1'b1, 18'h00020, 18'h00100);
    acks = 0;
    gap  = 0;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      @(negedge clk);
      if (bus_if.loader_ack) begin
        acks++;
        chk("b2b_mem", mem[bus_if.loader_addr[7:0]], bus_if.loader_wdata);
        if (acks > 1) chk("b2b_gap", gap, 1);
        gap = 0;
        if (acks == 3) begin
          bus_if.loader_req = 1'b0;
        end else begin
          bus_if.loader_addr  = bus_if.loader_addr + 18'd1;
          bus_if.loader_wdata = bus_if.loader_wdata + 18'h00111;
          push(1'b1, bus_if.loader_addr, bus_if.loader_wdata);
        end
      end else if (!bus_if.fetch_stall) begin
        gap++;
      end
    end
    chk("b2b_acks", acks, 3);

    @(posedge clk); #1;
    bus_if.loader_lock  = 1'b1;
    bus_if.loader_req   = 1'b1;
    bus_if.loader_we    = 1'b1;
    bus_if.loader_addr  = 18'h00040;
    bus_if.loader_wdata = 18'h3F000;
    push(1'b1, 18'h00040, 18'h3F000);
    @(negedge clk);
    chk("lock_pre_cpurst", bus_if.cpu_reset, 0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("lock_stall", bus_if.fetch_stall, 1);
      chk("lock_cpurst", bus_if.cpu_reset, 1);
      if (bus_if.loader_ack) begin
        acks++;
        if (acks == 4) begin
          bus_if.loader_req  = 1'b0;
          bus_if.loader_lock = 1'b0;
        end else begin
          bus_if.loader_addr  = bus_if.loader_addr + 18'd1;
          bus_if.loader_wdata = bus_if.loader_wdata + 18'h00005;
          push(1'b1, bus_if.loader_addr, bus_if.loader_wdata);
        end
      end
    end
    chk("lock_acks", acks, 4);
    @(negedge clk);
    chk("unlock_cpurst", bus_if.cpu_reset, 0);
    chk("unlock_stall", bus_if.fetch_stall, 0);

    access(1'b0, 18'h00043, 18'h0);

    @(posedge clk); #1;
    bus_if.loader_lock  = 1'b1;
    bus_if.loader_req   = 1'b1;
    bus_if.loader_we    = 1'b1;
    bus_if.loader_addr  = 18'h00060;
    bus_if.loader_wdata = 18'h00777;
    push(1'b1, 18'h00060, 18'h00777);
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_we", bus_if.mem_we, 1);
    chk("arst_pre_cpurst", bus_if.cpu_reset, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", bus_if.mem_we, 0);
    chk("arst_ack", bus_if.loader_ack, 0);
    chk("arst_cpurst", bus_if.cpu_reset, 0);
    chk("arst_stall", bus_if.fetch_stall, 0);
    sb.delete();
    bus_if.loader_req  = 1'b0;
    bus_if.loader_lock = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    access(1'b0, 18'h00005, 18'h0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_mem_arbiter.md
Name: code_mem_arbiter

Overview:
Shares the single-port synchronous code memory between the instruction fetch stage and an external program loader/debug port. Owns the memory address/write lines. Sequences loader reads and writes, and stalls fetch through the fetch stage's no_operation input while the loader holds the port. Optionally holds the CPU in reset for bulk program download.

Parameters:
ADDR_SIZE, 18, code memory address width
WORD_SIZE, 18, code memory word width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
fetch_addr  in  ADDR_SIZE  fetch stage code_addr (current ip)
fetch_data  out  WORD_SIZE  instruction word to fetch pipeline, equals mem_rdata
fetch_stall  out  1  drives fetch stage no_operation; high = hold ip
loader_req  in  1  loader access request, level
loader_we  in  1  1 = write, 0 = read; sampled with request
loader_addr  in  ADDR_SIZE  loader address
loader_wdata  in  WORD_SIZE  loader write data
loader_lock  in  1  exclusive download mode
loader_ack  out  1  one-cycle completion pulse
loader_rdata  out  WORD_SIZE  registered read result
cpu_reset  out  1  active-high reset request to processor pipeline
mem_addr  out  ADDR_SIZE  code memory address
mem_we  out  1  code memory write enable
mem_wdata  out  WORD_SIZE  code memory write data
mem_rdata  in  WORD_SIZE  code memory read data, 1-cycle synchronous latency

Behaviour:
- States: FETCH, LOAD, DONE. Reset (reset=0, async) -> FETCH; loader_ack=0, loader_rdata=0, cpu_reset=0.
- Output decode (combinational from state and inputs):
  - FETCH: mem_addr=fetch_addr, mem_we=0, fetch_stall=0.
  - LOAD: mem_addr=loader_addr, mem_we=loader_we, mem_wdata=loader_wdata, fetch_stall=1.
  - DONE: mem_addr=fetch_addr (re-issues the fetch of the held ip), mem_we=0, fetch_stall=1.
  - mem_wdata=loader_wdata in all states; only mem_we qualifies it.
- fetch_data = mem_rdata always. The fetch issued in the cycle before LOAD returns during LOAD and is valid for the pipeline.
- Transitions:
  - FETCH -> LOAD when loader_req=1.
  - LOAD -> DONE unconditionally.
  - DONE -> LOAD if loader_req=1 and loader_lock=1; otherwise DONE -> FETCH.
  - Without lock, at least one FETCH cycle separates loader accesses, so fetch is never starved; each loader access costs exactly 2 stall cycles.
- Loader handshake:
  - loader_addr, loader_we and loader_wdata must be stable from request until ack.
  - loader_ack=1 for exactly the DONE cycle, registered.
  - Read: loader_rdata <= mem_rdata on the LOAD->DONE edge, so it is valid while ack=1 and held until the next read. Write: loader_rdata unchanged.
  - loader_req still high in the ack cycle is treated as a new request: it is taken from DONE if locked, otherwise at the next FETCH cycle.
- Request latency: loader_req rising in FETCH gives ack 2 cycles later (cycle+2).
- cpu_reset: registered.
  - Set to 1 on the first edge where loader_lock=1.
  - Cleared on the first edge where loader_lock=0 and next state is FETCH.
  - It never drops while a locked access is in LOAD/DONE.
- Lock asserted mid-access: it affects only the DONE transition and cpu_reset; the current access completes normally.
- reset asserted mid-access: the access is abandoned immediately, with no ack and mem_we=0 once reset propagates. A write in progress is undefined at memory; the loader must retry.
- Address/data widths: pass-through, no arithmetic, no wrap handling.

Test Plan:
- Idle fetch: loader_req=0, fetch_addr steps 0,1,2 -> mem_addr follows, mem_we=0, fetch_stall=0, loader_ack never 1.
- Single write: in FETCH drive req=1, we=1, addr=0x00010, wdata=0x2ABCD -> next cycle mem_addr=0x00010, mem_we=1, stall=1; then ack=1, stall=1, mem_addr=fetch_addr; then FETCH, stall=0.
- Single read: memory preloaded 0x00005=0x12345, req=1, we=0, addr=0x00005 -> loader_rdata=0x12345 with ack=1 two cycles after request; fetch_addr held constant during stall.
- Back-to-back unlocked: req held high for 3 accesses -> state sequence LOAD,DONE,FETCH repeating; exactly one stall=0 cycle between acks.
- Locked download: lock=1, 4 consecutive writes with req held -> cpu_reset=1 from first edge, LOAD/DONE alternate with no FETCH cycle, 4 acks in 8 cycles; lock=0 -> cpu_reset=0 one edge after return to FETCH.
- Async reset in LOAD: drive reset=0 between edges -> state FETCH, mem_we=0, loader_ack=0, cpu_reset=0 immediately without a clock edge.
